bcd_feeder: RTL and testbench



---
 rtl/bcd_feeder.sv | 182 ++++++++++++++++++
 tb/tb_bcd_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_feeder.sv
// bcd_feeder: bus front end that converts binary to packed BCD and issues digit/dp writes to the 7-segment driver.
// Latency: DEC digit write sampled 17 edges after acceptance, dp write at 18; HEX at 1/2; lone DP at 1.
// Backpressure: none; DEC/HEX arriving while busy park in a one-deep slot (latest wins); DP updates dp at once.
module bcd_feeder #(
  parameter logic [31:0] BASE    = 32'h20,
  parameter logic [31:0] SEGBASE = 32'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        seg_enable,
  output logic        seg_rw,
  output logic [31:0] seg_addr,
  output logic [31:0] seg_data,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, CONV, WDIG, WDP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d;
  logic        ovf_q, ovf_d;
  logic        slot_vld_q, slot_vld_d;
  logic        slot_hex_q, slot_hex_d;
  logic [15:0] slot_val_q, slot_val_d;

  logic        wr, dec_wr, dp_wr, hex_wr;
  logic        cmd_go, cmd_hex;
  logic [15:0] cmd_val;
  logic [19:0] bcd_adj;
  logic [19:0] bcd_sh;
  logic [15:0] bin_sh;
  logic        unused_data;

  assign wr          = enable & rw;
  assign dec_wr      = wr && (addr == BASE);
  assign dp_wr       = wr && (addr == BASE + 32'd1);
  assign hex_wr      = wr && (addr == BASE + 32'd2);
  assign unused_data = ^data[31:16];

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[18:0], bin_q[15]};
    bin_sh = {bin_q[14:0], 1'b0};
  end

  // Next-state logic: command launch, conversion steps and pending-slot handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    digits_d   = digits_q;
    dp_d       = dp_q;
    ovf_d      = ovf_q;
    slot_vld_d = slot_vld_q;
    slot_hex_d = slot_hex_q;
    slot_val_d = slot_val_q;
    cmd_go     = 1'b0;
    cmd_hex    = 1'b0;
    cmd_val    = 16'h0;

    if (dp_wr) dp_d = data[3:0];

    case (state_q)
      IDLE: begin
        if (dec_wr || hex_wr) begin
          cmd_go  = 1'b1;
          cmd_hex = hex_wr;
          cmd_val = data[15:0];
        end else if (dp_wr) begin
          state_d = WDP;
        end
      end
      CONV: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d  = WDIG;
          digits_d = (bcd_sh[19:16] != 4'd0) ? 16'hFFFF : bcd_sh[15:0];
          ovf_d    = (bcd_sh[19:16] != 4'd0);
        end
      end
      WDIG: state_d = WDP;
      default: begin
        // A write landing on the WDP exit edge beats whatever sits in the slot.
        if (dec_wr || hex_wr) begin
          cmd_go     = 1'b1;
          cmd_hex    = hex_wr;
          cmd_val    = data[15:0];
          slot_vld_d = 1'b0;
        end else if (slot_vld_q) begin
          cmd_go     = 1'b1;
          cmd_hex    = slot_hex_q;
          cmd_val    = slot_val_q;
          slot_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if ((dec_wr || hex_wr) && (state_q == CONV || state_q == WDIG)) begin
      slot_vld_d = 1'b1;
      slot_hex_d = hex_wr;
      slot_val_d = data[15:0];
    end

    if (cmd_go) begin
      if (cmd_hex) begin
        state_d  = WDIG;
        digits_d = cmd_val;
      end else begin
        state_d = CONV;
        bin_d   = cmd_val;
        bcd_d   = 20'h0;
        cnt_d   = 4'd0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      bin_q      <= 16'h0;
      bcd_q      <= 20'h0;
      digits_q   <= 16'h0;
      dp_q       <= 4'h0;
      ovf_q      <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_hex_q <= 1'b0;
      slot_val_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      ovf_q      <= ovf_d;
      slot_vld_q <= slot_vld_d;
      slot_hex_q <= slot_hex_d;
      slot_val_q <= slot_val_d;
    end
  end

  // Outbound bus decoded purely from registered state.
  always_comb begin
    seg_enable = 1'b0;
    seg_addr   = 32'h0;
    seg_data   = 32'h0;
    if (state_q == WDIG) begin
      seg_enable = 1'b1;
      seg_addr   = SEGBASE;
      seg_data   = {16'h0, digits_q};
    end else if (state_q == WDP) begin
      seg_enable = 1'b1;
      seg_addr   = SEGBASE + 32'd1;
      seg_data   = {28'h0, dp_q};
    end
  end

  assign seg_rw   = seg_enable;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_feeder.sv
// Testbench for bcd_feeder: randomized and directed bus writes against a command-level timing model.
// Expected outbound writes are queued with their sampling edge; a negedge monitor pops and compares.
// Busy and idle-bus values are checked every cycle.
module tb_bcd_feeder;

  localparam logic [31:0] BASE    = 32'h20;
  localparam logic [31:0] SEGBASE = 32'h10;
  localparam int K_NONE = 0, K_DEC = 1, K_DP = 2, K_HEX = 3, K_OTHER = 4, K_READ = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, rw = 1'b0;
  logic [31:0] addr = 32'h0, data = 32'h0;
  logic        seg_enable, seg_rw, busy, overflow;
  logic [31:0] seg_addr, seg_data;

  bcd_feeder #(.BASE(BASE), .SEGBASE(SEGBASE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rw(rw), .addr(addr), .data(data),
    .seg_enable(seg_enable), .seg_rw(seg_rw), .seg_addr(seg_addr), .seg_data(seg_data),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [31:0] a;
    logic [31:0] d;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  bit   mon_en = 0;

  // command-level model state
  int          dig_at_m = -1;
  int          dp_at_m  = -1;
  logic [15:0] digits_m = 16'h0;
  logic [3:0]  dp_m     = 4'h0;
  logic        ovf_m    = 1'b0;
  bit          pend_vld = 0;
  bit          pend_hex = 0;
  logic [15:0] pend_val = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v % 10) | (((v / 10) % 10) << 4) | (((v / 100) % 10) << 8) | (((v / 1000) % 10) << 12));
  endfunction

  task automatic start_cmd(input int t, input bit hex, input logic [15:0] v);
    if (hex) begin
      dig_at_m = t + 1;
      dp_at_m  = t + 2;
      digits_m = v;
    end else begin
      dig_at_m = t + 17;
      dp_at_m  = t + 18;
      ovf_m    = (int'(v) > 9999);
      digits_m = ovf_m ? 16'hFFFF : to_bcd(int'(v));
    end
  endtask

  task automatic model_reset();
    q.delete();
    dig_at_m = -1;
    dp_at_m  = -1;
    digits_m = 16'h0;
    dp_m     = 4'h0;
    ovf_m    = 1'b0;
    pend_vld = 0;
  endtask

  // Apply the write accepted at edge t, then queue whatever the driver samples at edge t+1.
  task automatic model_step(input int t, input int kind, input logic [15:0] v);
    bit cmd;
    cmd = (kind == K_DEC) || (kind == K_HEX);
    if (kind == K_DP) dp_m = v[3:0];
    if (t > dp_at_m) begin
      if (cmd) start_cmd(t, kind == K_HEX, v);
      else if (kind == K_DP) begin
        dig_at_m = -1;
        dp_at_m  = t + 1;
      end
    end else if (t < dp_at_m) begin
      if (cmd) begin
        pend_vld = 1;
        pend_hex = (kind == K_HEX);
        pend_val = v;
      end
    end else begin
      if (cmd) begin
        start_cmd(t, kind == K_HEX, v);
        pend_vld = 0;
      end else if (pend_vld) begin
        start_cmd(t, pend_hex, pend_val);
        pend_vld = 0;
      end
    end
    if (dig_at_m == t + 1) q.push_back('{t + 1, SEGBASE, {16'h0, digits_m}, ovf_m});
    if (dp_at_m == t + 1)  q.push_back('{t + 1, SEGBASE + 32'd1, {28'h0, dp_m}, ovf_m});
  endtask

  task automatic cycle(input int kind, input logic [15:0] v);
    @(negedge clk);
    enable = 1'b0; rw = 1'b0; addr = 32'h0; data = 32'h0;
    if (kind != K_NONE) begin
      enable = 1'b1;
      rw     = (kind != K_READ);
      data   = $urandom;
      data[15:0] = v;
      case (kind)
        K_DEC:   addr = BASE;
        K_DP:    addr = BASE + 32'd1;
        K_HEX:   addr = BASE + 32'd2;
        K_OTHER: addr = ($urandom_range(0, 1) == 0) ? BASE + 32'd3 : SEGBASE;
        default: addr = BASE;
      endcase
    end
    @(posedge clk);
    model_step(edge_n, kind, v);
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(K_NONE, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg_enable"}, {31'h0, seg_enable}, 32'h0);
    chk({tag, "_seg_rw"}, {31'h0, seg_rw}, 32'h0);
    chk({tag, "_seg_addr"}, seg_addr, 32'h0);
    chk({tag, "_seg_data"}, seg_data, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_overflow"}, {31'h0, overflow}, 32'h0);
  endtask

  // Monitor: pop expected writes whenever the DUT strobes, and flag missing/extra ones.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'h0, busy}, {31'h0, (dp_at_m >= edge_n)});
      if (seg_enable) begin
        chk("seg_rw", {31'h0, seg_rw}, 32'h1);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h required=none (edge %0d)", seg_addr, seg_data, edge_n);
        end else begin
          e = q.pop_front();
          chk("wr_edge", edge_n, e.at);
          chk("wr_addr", seg_addr, e.a);
          chk("wr_data", seg_data, e.d);
          chk("wr_overflow", {31'h0, overflow}, {31'h0, e.ovf});
        end
      end else begin
        chk("idle_addr", seg_addr, 32'h0);
        chk("idle_data", seg_data, 32'h0);
        if (q.size() > 0 && q[0].at <= edge_n) begin
          e = q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_write actual=none required=addr %h data %h (edge %0d)", e.a, e.d, e.at);
        end
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1;

    cycle(K_DEC, 16'd1234);   idle(22);
    cycle(K_DEC, 16'd65535);  idle(22);
    cycle(K_DEC, 16'd9999);   idle(22);
    cycle(K_HEX, 16'hBEEF);   idle(4);
    cycle(K_DP, 16'h5);       idle(4);
    cycle(K_DEC, 16'd42);     idle(3);
    cycle(K_DEC, 16'd7);      idle(2);
    cycle(K_HEX, 16'hA5A5);
    cycle(K_DP, 16'hF);       idle(40);
    cycle(K_HEX, 16'h1111);
    cycle(K_HEX, 16'h2222);
    cycle(K_HEX, 16'h3333);   idle(6);
    cycle(K_READ, 16'd55);
    cycle(K_OTHER, 16'd66);   idle(3);

    // Reset while the conversion counter sits at 8.
    cycle(K_DEC, 16'd321);
    idle(8);
    @(negedge clk);
    enable = 1'b0; rw = 1'b0; addr = 32'h0; data = 32'h0;
    #3 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    edge_n++;
    idle(3);
    @(negedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    edge_n++;
    idle(40);
    cycle(K_DEC, 16'd0);      idle(22);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 68)      cycle(K_NONE, 16'h0);
      else if (r < 78) cycle(K_DEC, ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom));
      else if (r < 85) cycle(K_DP, 16'($urandom_range(0, 15)));
      else if (r < 92) cycle(K_HEX, 16'($urandom));
      else if (r < 96) cycle(K_OTHER, 16'($urandom));
      else             cycle(K_READ, 16'($urandom));
    end
    idle(40);

    chk("queue_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
